// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int unsigned BCD_W       = 4;
    localparam int unsigned ADD3_THRESH = 5;
    localparam int unsigned MAX_DIGITS  = 10;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

    // All-nines BCD vector with the low n digits set; callers slice to their width.
    function automatic logic [MAX_DIGITS*BCD_W-1:0] all_nines(input int unsigned n);
        logic [MAX_DIGITS*BCD_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (i < n) v[i*BCD_W +: BCD_W] = 4'd9;
        end
        return v;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Single-digit shift-add-3 adjust; the result never exceeds 12, so no inter-digit carry.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit_i,
    output logic [BCD_W-1:0] digit_o
);

    assign digit_o = (digit_i >= BCD_W'(ADD3_THRESH)) ? digit_i + BCD_W'(3) : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-packed-BCD converter: one add-3 plus shift per clock, with
// valid/ready on both sides, optional signed input, overflow saturation and blank mask.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W     = 20,
    parameter int unsigned DIGITS    = 6,
    parameter int unsigned SIGNED_EN = 0
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BIN_W-1:0]        in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BCD_W*DIGITS-1:0] out_bcd,
    output logic                    out_neg,
    output logic                    out_ovf,
    output logic [DIGITS-1:0]       out_blank
);

    localparam int unsigned BCD_V = BCD_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W) + 1;
    localparam logic [MAX_DIGITS*BCD_W-1:0] NINES_ALL = all_nines(DIGITS);
    localparam logic [BCD_V-1:0] NINES = NINES_ALL[BCD_V-1:0];

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [BCD_V-1:0]  bcd_q;
    logic [BIN_W-1:0]  bin_q;
    logic              ovf_q, neg_q;

    logic [BCD_V-1:0]  bcd_adj, bcd_step, bcd_sat;
    logic [BIN_W-1:0]  bin_step, mag;
    logic              carry_out, ovf_step, last_iter, is_neg;
    logic [DIGITS-1:0] blank_sat;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i(bcd_q[g*BCD_W +: BCD_W]),
            .digit_o(bcd_adj[g*BCD_W +: BCD_W])
        );
    end

    // The bit leaving the top digit means the magnitude no longer fits.
    assign {carry_out, bcd_step, bin_step} = {bcd_adj, bin_q, 1'b0};
    assign ovf_step  = ovf_q | carry_out;
    assign bcd_sat   = ovf_step ? NINES : bcd_step;
    assign last_iter = (cnt_q == CNT_W'(BIN_W - 1));

    assign is_neg = (SIGNED_EN != 0) && in_data[BIN_W-1];
    assign mag    = is_neg ? -in_data : in_data;

    always_comb begin
        logic all_zero;
        all_zero  = 1'b1;
        blank_sat = '0;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            all_zero     = all_zero & (bcd_sat[d*BCD_W +: BCD_W] == '0);
            blank_sat[d] = all_zero;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = CONV;
            CONV:    if (last_iter) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) & ~sys_rst;
        out_valid = (state_q == DONE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q     <= '0;
            bcd_q     <= '0;
            bin_q     <= '0;
            ovf_q     <= 1'b0;
            neg_q     <= 1'b0;
            out_bcd   <= '0;
            out_neg   <= 1'b0;
            out_ovf   <= 1'b0;
            out_blank <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        bcd_q <= '0;
                        bin_q <= mag;
                        cnt_q <= '0;
                        ovf_q <= 1'b0;
                        neg_q <= is_neg;
                    end
                end
                CONV: begin
                    bcd_q <= bcd_step;
                    bin_q <= bin_step;
                    ovf_q <= ovf_step;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_iter) begin
                        out_bcd   <= bcd_sat;
                        out_neg   <= neg_q;
                        out_ovf   <= ovf_step;
                        out_blank <= blank_sat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench: an unsigned and a signed converter instance checked against
// a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;
    logic sys_rst;

    logic        u_in_valid, u_in_ready, u_out_valid, u_out_ready, u_out_neg, u_out_ovf;
    logic [19:0] u_in_data;
    logic [23:0] u_out_bcd;
    logic [5:0]  u_out_blank;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_neg, s_out_ovf;
    logic [19:0] s_in_data;
    logic [23:0] s_out_bcd;
    logic [5:0]  s_out_blank;

    int total  = 0;
    int passed = 0;

    bin2bcd_seq #(.BIN_W(20), .DIGITS(6), .SIGNED_EN(0)) u_dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .in_valid(u_in_valid), .in_ready(u_in_ready), .in_data(u_in_data),
        .out_valid(u_out_valid), .out_ready(u_out_ready), .out_bcd(u_out_bcd),
        .out_neg(u_out_neg), .out_ovf(u_out_ovf), .out_blank(u_out_blank)
    );

    bin2bcd_seq #(.BIN_W(20), .DIGITS(6), .SIGNED_EN(1)) s_dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_bcd(s_out_bcd),
        .out_neg(s_out_neg), .out_ovf(s_out_ovf), .out_blank(s_out_blank)
    );

    // ---------------- reference model ----------------
    function automatic longint unsigned pow10(input int n);
        longint unsigned r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic longint unsigned model_mag(input logic [19:0] d, input bit signed_en);
        if (signed_en && d[19]) return 64'd1048576 - 64'(d);
        return 64'(d);
    endfunction

    function automatic logic model_ovf(input longint unsigned m);
        return m > 64'd999999;
    endfunction

    function automatic logic [23:0] model_bcd(input longint unsigned m);
        logic [23:0] r = '0;
        if (m > 64'd999999) m = 64'd999999;
        for (int i = 0; i < 6; i++) r[4*i +: 4] = 4'((m / pow10(i)) % 10);
        return r;
    endfunction

    function automatic logic [5:0] model_blank(input longint unsigned m);
        logic [5:0] b = '0;
        if (m > 64'd999999) m = 64'd999999;
        for (int d = 1; d < 6; d++) b[d] = (m < pow10(d));
        return b;
    endfunction

    // ---------------- driver ----------------
    task automatic run(input bit sel, input logic [19:0] d, output logic [23:0] bcd,
                       output logic ovf, output logic neg, output logic [5:0] blank,
                       output int lat);
        int guard = 0;
        @(negedge sys_clk);
        if (sel) begin s_in_valid = 1'b1; s_in_data = d; end
        else     begin u_in_valid = 1'b1; u_in_data = d; end
        while (!(sel ? s_in_ready : u_in_ready) && guard < 50) begin
            @(negedge sys_clk);
            guard++;
        end
        if (guard >= 50) begin
            total++;
            $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", guard);
        end
        @(posedge sys_clk); #1;
        u_in_valid = 1'b0;
        s_in_valid = 1'b0;
        lat = 0;
        while (!(sel ? s_out_valid : u_out_valid) && lat < 100) begin
            @(posedge sys_clk); #1;
            lat++;
        end
        if (!(sel ? s_out_valid : u_out_valid)) begin
            total++;
            $display("FAIL result_timeout: out_valid=0 after %0d cycles, required 1", lat);
        end
        bcd   = sel ? s_out_bcd   : u_out_bcd;
        ovf   = sel ? s_out_ovf   : u_out_ovf;
        neg   = sel ? s_out_neg   : u_out_neg;
        blank = sel ? s_out_blank : u_out_blank;
        @(negedge sys_clk);
        u_out_ready = sel ? 1'b0 : 1'b1;
        s_out_ready = sel ? 1'b1 : 1'b0;
        @(posedge sys_clk); #1;
        u_out_ready = 1'b0;
        s_out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        total++;
        if ({u_in_ready, s_in_ready} !== 2'b00)
            $display("FAIL reset_in_ready: got %b, required 00", {u_in_ready, s_in_ready});
        else passed++;
        total++;
        if ({u_out_valid, u_out_bcd, u_out_ovf, u_out_neg, u_out_blank} !== 33'd0)
            $display("FAIL reset_outputs: got %h, required 0",
                     {u_out_valid, u_out_bcd, u_out_ovf, u_out_neg, u_out_blank});
        else passed++;
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;
        total++;
        if ({u_in_ready, s_in_ready} !== 2'b11)
            $display("FAIL release_in_ready: got %b, required 11", {u_in_ready, s_in_ready});
        else passed++;
    endtask

    task automatic test_directed();
        logic [19:0] vals [7] = '{20'd999999, 20'd1048575, 20'd0, 20'd12345,
                                  20'd1000000, 20'd1, 20'd100000};
        logic [23:0] bcd; logic ovf, neg; logic [5:0] blank; int lat;
        longint unsigned m;
        foreach (vals[i]) begin
            run(1'b0, vals[i], bcd, ovf, neg, blank, lat);
            m = model_mag(vals[i], 1'b0);
            total++;
            if (lat !== 20)
                $display("FAIL dir_latency[%0d]: got %0d, required 20", vals[i], lat);
            else passed++;
            total++;
            if ({bcd, ovf, neg, blank} !== {model_bcd(m), model_ovf(m), 1'b0, model_blank(m)})
                $display("FAIL dir_result[%0d]: got bcd=%h ovf=%b neg=%b blank=%b, required bcd=%h ovf=%b neg=0 blank=%b",
                         vals[i], bcd, ovf, neg, blank, model_bcd(m), model_ovf(m), model_blank(m));
            else passed++;
        end
    endtask

    task automatic test_signed();
        logic [23:0] bcd; logic ovf, neg; logic [5:0] blank; int lat;
        logic [19:0] d;
        longint unsigned m;
        for (int i = 0; i < 24; i++) begin
            case (i)
                0:       d = 20'h80000;
                1:       d = 20'hFFFFF;
                2:       d = 20'h00000;
                3:       d = 20'h7FFFF;
                default: d = 20'($urandom);
            endcase
            run(1'b1, d, bcd, ovf, neg, blank, lat);
            m = model_mag(d, 1'b1);
            total++;
            if ({bcd, ovf, neg, blank} !== {model_bcd(m), model_ovf(m), d[19], model_blank(m)})
                $display("FAIL signed_result[%h]: got bcd=%h ovf=%b neg=%b blank=%b, required bcd=%h ovf=%b neg=%b blank=%b",
                         d, bcd, ovf, neg, blank, model_bcd(m), model_ovf(m), d[19], model_blank(m));
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [23:0] bcd; logic ovf, neg; logic [5:0] blank; int lat;
        logic [19:0] d;
        longint unsigned m;
        for (int i = 0; i < 30; i++) begin
            case (i % 3)
                0:       d = 20'($urandom);
                1:       d = 20'(999990 + $urandom_range(0, 20));
                default: d = 20'($urandom_range(0, 9999));
            endcase
            run(1'b0, d, bcd, ovf, neg, blank, lat);
            m = model_mag(d, 1'b0);
            total++;
            if ({bcd, ovf, neg, blank, lat} !==
                {model_bcd(m), model_ovf(m), 1'b0, model_blank(m), 32'd20})
                $display("FAIL random_result[%0d]: got bcd=%h ovf=%b neg=%b blank=%b lat=%0d, required bcd=%h ovf=%b neg=0 blank=%b lat=20",
                         d, bcd, ovf, neg, blank, lat, model_bcd(m), model_ovf(m), model_blank(m));
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        logic [32:0] snap;
        longint unsigned m = 654321;
        int guard = 0;
        bit seen;
        @(negedge sys_clk);
        u_in_valid = 1'b1;
        u_in_data  = 20'd654321;
        @(posedge sys_clk); #1;
        u_in_valid = 1'b0;
        while (!u_out_valid && guard < 100) begin
            @(posedge sys_clk); #1;
            guard++;
        end
        snap = {u_out_valid, u_out_bcd, u_out_ovf, u_out_neg, u_out_blank};
        total++;
        if (snap !== {1'b1, model_bcd(m), 1'b0, 1'b0, model_blank(m)})
            $display("FAIL bp_result: got %h, required %h", snap,
                     {1'b1, model_bcd(m), 1'b0, 1'b0, model_blank(m)});
        else passed++;
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            u_in_valid = 1'b1;
            u_in_data  = 20'($urandom);
            total++;
            if ({u_out_valid, u_out_bcd, u_out_ovf, u_out_neg, u_out_blank, u_in_ready} !==
                {snap, 1'b0})
                $display("FAIL bp_hold[%0d]: got %h in_ready=%b, required %h in_ready=0", i,
                         {u_out_valid, u_out_bcd, u_out_ovf, u_out_neg, u_out_blank},
                         u_in_ready, snap);
            else passed++;
        end
        @(negedge sys_clk);
        u_in_valid  = 1'b0;
        u_out_ready = 1'b1;
        @(posedge sys_clk); #1;
        u_out_ready = 1'b0;
        total++;
        if ({u_out_valid, u_in_ready} !== 2'b01)
            $display("FAIL bp_release: got out_valid=%b in_ready=%b, required 0 1",
                     u_out_valid, u_in_ready);
        else passed++;
        seen = 1'b0;
        repeat (25) begin
            @(posedge sys_clk); #1;
            if (u_out_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) $display("FAIL bp_ignored_pulses: got out_valid=1, required 0");
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [23:0] bcd; logic ovf, neg; logic [5:0] blank; int lat;
        bit seen = 1'b0;
        @(negedge sys_clk);
        u_in_valid = 1'b1;
        u_in_data  = 20'd777777;
        @(posedge sys_clk); #1;
        u_in_valid = 1'b0;
        repeat (7) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        total++;
        if ({u_out_valid, u_out_bcd, u_out_ovf, u_out_neg, u_out_blank, u_in_ready} !== 34'd0)
            $display("FAIL midrst_outputs: got %h, required 0",
                     {u_out_valid, u_out_bcd, u_out_ovf, u_out_neg, u_out_blank, u_in_ready});
        else passed++;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        #1;
        total++;
        if (u_in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b, required 1", u_in_ready);
        else passed++;
        repeat (25) begin
            @(posedge sys_clk); #1;
            if (u_out_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) $display("FAIL midrst_stale: got out_valid=1, required 0");
        else passed++;
        run(1'b0, 20'd4321, bcd, ovf, neg, blank, lat);
        total++;
        if ({bcd, ovf, blank, lat} !== {24'h004321, 1'b0, 6'b110000, 32'd20})
            $display("FAIL midrst_new: got bcd=%h ovf=%b blank=%b lat=%0d, required 004321 0 110000 20",
                     bcd, ovf, blank, lat);
        else passed++;
    endtask

    initial begin
        sys_rst     = 1'b1;
        u_in_valid  = 1'b0; u_in_data = '0; u_out_ready = 1'b0;
        s_in_valid  = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
        test_reset();
        test_directed();
        test_signed();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
